// File: rtl/mem_ftch_pkg.sv
// Shared types for the mem_ftch interface: beat packet, read-pipe tag and
// the transmitter state encoding.
package mem_ftch_pkg;

  localparam int MEM_FTCH_LINE_WORDS = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } mem_ftch_xmtr_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        crit;
    logic        last;
  } mem_ftch_pkt_t;

  typedef struct packed {
    logic        vld;
    logic [31:0] addr;
    logic        crit;
    logic        last;
  } mem_ftch_tag_t;

endpackage

// File: rtl/mem_ftch_rd_pipe.sv
// Tag shift register that tracks each memory read until its data returns.
// A kill drops every tag in flight.
module mem_ftch_rd_pipe
  import mem_ftch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          kill_i,
  input  mem_ftch_tag_t tag_i,
  output mem_ftch_tag_t tag_o
);

  mem_ftch_tag_t stage_q [DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else if (kill_i) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/mem_ftch_xmtr.sv
// Memory-side mem_ftch transmitter: fetches one line critical-word-first from
// a fixed-latency read port and streams one beat per returned word.
module mem_ftch_xmtr
  import mem_ftch_pkg::*;
#(
  parameter int LINE_WORDS = MEM_FTCH_LINE_WORDS,
  parameter int MEM_LAT    = 2
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          ftch_req_vld,
  input  logic [31:0]   ftch_req_addr,
  output logic          ftch_req_rdy,
  input  logic          flush,
  output logic          mem_rd_en,
  output logic [31:0]   mem_rd_addr,
  input  logic [31:0]   mem_rd_data,
  output logic          mem_ftch_vld,
  output mem_ftch_pkt_t mem_ftch_pkt,
  output logic          busy
);

  localparam int              IDXW      = $clog2(LINE_WORDS);
  localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(LINE_WORDS - 1);
  localparam logic [31:0]     LINE_MASK = 32'(LINE_WORDS * 4 - 1);

  mem_ftch_xmtr_state_e state_q, state_d;
  logic [IDXW-1:0]      cnt_q, cnt_d;
  logic [IDXW-1:0]      crit_idx_q, crit_idx_d;
  logic [IDXW-1:0]      nxt_idx;
  logic [31:0]          base_q, base_d;
  logic                 rd_en_q, rd_en_d;
  logic [31:0]          rd_addr_q, rd_addr_d;
  logic                 vld_q, vld_d;
  mem_ftch_pkt_t        pkt_q, pkt_d;
  logic                 busy_q, busy_d;
  mem_ftch_tag_t        pipe_in, pipe_out;

  // Each read carries its tag through the pipe so the beat can be rebuilt on return.
  always_comb begin
    pipe_in      = '0;
    pipe_in.vld  = rd_en_q;
    pipe_in.addr = rd_addr_q;
    pipe_in.crit = rd_en_q && (cnt_q == '0);
    pipe_in.last = rd_en_q && (cnt_q == LAST_IDX);
  end

  mem_ftch_rd_pipe #(.DEPTH(MEM_LAT)) u_rd_pipe (
    .clk_i  (clk),
    .rst_i  (resetn),
    .kill_i (flush),
    .tag_i  (pipe_in),
    .tag_o  (pipe_out)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    crit_idx_d = crit_idx_q;
    base_d     = base_q;
    rd_en_d    = 1'b0;
    rd_addr_d  = '0;
    nxt_idx    = crit_idx_q + cnt_q + 1'b1;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (ftch_req_vld) begin
            base_d     = ftch_req_addr & ~LINE_MASK;
            crit_idx_d = ftch_req_addr[IDXW+1:2];
            cnt_d      = '0;
            rd_en_d    = 1'b1;
            rd_addr_d  = ftch_req_addr & ~32'h3;
            state_d    = ISSUE;
          end
        end
        ISSUE: begin
          if (cnt_q == LAST_IDX) begin
            state_d = DRAIN;
          end else begin
            cnt_d     = cnt_q + 1'b1;
            rd_en_d   = 1'b1;
            rd_addr_d = base_q | {{(30-IDXW){1'b0}}, nxt_idx, 2'b00};
          end
        end
        DRAIN: begin
          // The last tag leaving the pipe empties it on this same edge.
          if (pipe_out.vld && pipe_out.last) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    vld_d  = 1'b0;
    pkt_d  = '0;
    busy_d = (state_d != IDLE);
    if (!flush && pipe_out.vld) begin
      vld_d      = 1'b1;
      pkt_d.addr = pipe_out.addr;
      pkt_d.data = mem_rd_data;
      pkt_d.crit = pipe_out.crit;
      pkt_d.last = pipe_out.last;
    end
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      crit_idx_q <= '0;
      base_q     <= '0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      vld_q      <= 1'b0;
      pkt_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      crit_idx_q <= crit_idx_d;
      base_q     <= base_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      vld_q      <= vld_d;
      pkt_q      <= pkt_d;
      busy_q     <= busy_d;
    end
  end

  assign ftch_req_rdy = (state_q == IDLE) && !flush;
  assign mem_rd_en    = rd_en_q;
  assign mem_rd_addr  = rd_addr_q;
  assign mem_ftch_vld = vld_q;
  assign mem_ftch_pkt = pkt_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_mem_ftch_xmtr.sv
// Bench for mem_ftch_xmtr: a default instance and an 8-word/latency-1 instance
// share stimulus and are each compared cycle by cycle against a schedule model.
module tb_mem_ftch_xmtr;
  import mem_ftch_pkg::*;

  localparam int NCYC = 1024;
  localparam int LW0 = 4, ML0 = 2;
  localparam int LW1 = 8, ML1 = 1;

  logic          clk = 1'b0;
  logic          resetn;
  logic          reqVld;
  logic [31:0]   reqAddr;
  logic          flush;
  logic          rdy [2];
  logic          rdEn [2];
  logic [31:0]   rdAddr [2];
  logic [31:0]   memData [2];
  logic          vldO [2];
  mem_ftch_pkt_t pkt [2];
  logic          busyO [2];

  always #5 clk = ~clk;

  mem_ftch_xmtr #(.LINE_WORDS(LW0), .MEM_LAT(ML0)) dut (
    .clk(clk), .resetn(resetn), .ftch_req_vld(reqVld), .ftch_req_addr(reqAddr),
    .ftch_req_rdy(rdy[0]), .flush(flush), .mem_rd_en(rdEn[0]), .mem_rd_addr(rdAddr[0]),
    .mem_rd_data(memData[0]), .mem_ftch_vld(vldO[0]), .mem_ftch_pkt(pkt[0]), .busy(busyO[0])
  );

  mem_ftch_xmtr #(.LINE_WORDS(LW1), .MEM_LAT(ML1)) dut8 (
    .clk(clk), .resetn(resetn), .ftch_req_vld(reqVld), .ftch_req_addr(reqAddr),
    .ftch_req_rdy(rdy[1]), .flush(flush), .mem_rd_en(rdEn[1]), .mem_rd_addr(rdAddr[1]),
    .mem_rd_data(memData[1]), .mem_ftch_vld(vldO[1]), .mem_ftch_pkt(pkt[1]), .busy(busyO[1])
  );

  // Expected per-cycle activity, filled in when the model accepts a request.
  bit          expRdEn [2][NCYC];
  logic [31:0] expRdAddr [2][NCYC];
  bit          expVld [2][NCYC];
  logic [31:0] expPAddr [2][NCYC];
  bit          expCrit [2][NCYC];
  bit          expLast [2][NCYC];
  bit          expBusy [2][NCYC];
  bit          histEn [2][NCYC];
  logic [31:0] histAddr [2][NCYC];
  int          freeAt [2];
  int          cyc;
  int          total;
  int          bad;

  function automatic int lwOf(input int i);
    return (i == 0) ? LW0 : LW1;
  endfunction

  function automatic int mlOf(input int i);
    return (i == 0) ? ML0 : ML1;
  endfunction

  function automatic logic [31:0] memFn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_1234;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic clearFrom(input int i, input int from);
    for (int c = from; c < NCYC; c++) begin
      expRdEn[i][c]   = 1'b0;
      expRdAddr[i][c] = '0;
      expVld[i][c]    = 1'b0;
      expPAddr[i][c]  = '0;
      expCrit[i][c]   = 1'b0;
      expLast[i][c]   = 1'b0;
      expBusy[i][c]   = 1'b0;
    end
  endtask

  // Memory answers a read MEM_LAT cycles later; idle cycles return noise.
  task automatic driveMem();
    for (int i = 0; i < 2; i++) begin
      if (cyc - mlOf(i) >= 0 && histEn[i][cyc-mlOf(i)])
        memData[i] = memFn(histAddr[i][cyc-mlOf(i)]);
      else
        memData[i] = $urandom;
    end
  endtask

  task automatic checkCycle();
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("d%0d.rdEn", i), {31'b0, rdEn[i]}, {31'b0, expRdEn[i][cyc]});
      checkOutput($sformatf("d%0d.rdAddr", i), rdAddr[i], expRdAddr[i][cyc]);
      checkOutput($sformatf("d%0d.vld", i), {31'b0, vldO[i]}, {31'b0, expVld[i][cyc]});
      checkOutput($sformatf("d%0d.pktAddr", i), pkt[i].addr, expPAddr[i][cyc]);
      checkOutput($sformatf("d%0d.pktData", i), pkt[i].data,
                  expVld[i][cyc] ? memFn(expPAddr[i][cyc]) : 32'h0);
      checkOutput($sformatf("d%0d.crit", i), {31'b0, pkt[i].crit}, {31'b0, expCrit[i][cyc]});
      checkOutput($sformatf("d%0d.last", i), {31'b0, pkt[i].last}, {31'b0, expLast[i][cyc]});
      checkOutput($sformatf("d%0d.rdy", i), {31'b0, rdy[i]},
                  {31'b0, (cyc >= freeAt[i]) && !flush});
      checkOutput($sformatf("d%0d.busy", i), {31'b0, busyO[i]}, {31'b0, expBusy[i][cyc]});
    end
  endtask

  // Line schedule: read k in cycle a+1+k, beat k in cycle a+k+MEM_LAT+2.
  task automatic modelStep();
    for (int i = 0; i < 2; i++) begin
      int lw;
      int ml;
      logic [31:0] base;
      int crit;
      lw = lwOf(i);
      ml = mlOf(i);
      histEn[i][cyc]   = rdEn[i];
      histAddr[i][cyc] = rdAddr[i];
      if (flush) begin
        clearFrom(i, cyc + 1);
        if (freeAt[i] > cyc + 1) freeAt[i] = cyc + 1;
      end else if (reqVld && cyc >= freeAt[i]) begin
        base = reqAddr & ~(32'(lw * 4) - 32'd1);
        crit = int'((reqAddr >> 2) % 32'(lw));
        for (int k = 0; k < lw; k++) begin
          expRdEn[i][cyc+1+k]      = 1'b1;
          expRdAddr[i][cyc+1+k]    = base + 32'(((crit + k) % lw) * 4);
          expVld[i][cyc+k+ml+2]    = 1'b1;
          expPAddr[i][cyc+k+ml+2]  = base + 32'(((crit + k) % lw) * 4);
          expCrit[i][cyc+k+ml+2]   = (k == 0);
          expLast[i][cyc+k+ml+2]   = (k == lw - 1);
        end
        for (int c = cyc + 1; c <= cyc + lw + ml; c++) expBusy[i][c] = 1'b1;
        freeAt[i] = cyc + lw + ml + 1;
      end
    end
  endtask

  task automatic applyStimulus(input bit v, input logic [31:0] a, input bit f);
    if (cyc >= NCYC - 24) begin
      $display("[TB] FAIL cycleBudget cyc=%0d limit=%0d", cyc, NCYC - 24);
      $fatal(1, "[TB] cycle budget exceeded");
    end
    reqVld  = v;
    reqAddr = a;
    flush   = f;
    driveMem();
    @(negedge clk);
    checkCycle();
    modelStep();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Reset lands mid-cycle; the read issued this cycle still gets a memory reply.
  task automatic midReset();
    reqVld = 1'b0;
    flush  = 1'b0;
    driveMem();
    #2;
    resetn = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("d%0d.rstVld", i), {31'b0, vldO[i]}, 32'h0);
      checkOutput($sformatf("d%0d.rstRdEn", i), {31'b0, rdEn[i]}, 32'h0);
      checkOutput($sformatf("d%0d.rstRdAddr", i), rdAddr[i], 32'h0);
      checkOutput($sformatf("d%0d.rstBusy", i), {31'b0, busyO[i]}, 32'h0);
      checkOutput($sformatf("d%0d.rstPkt", i), pkt[i].addr | pkt[i].data, 32'h0);
      checkOutput($sformatf("d%0d.rstRdy", i), {31'b0, rdy[i]}, 32'h1);
      histEn[i][cyc]   = expRdEn[i][cyc];
      histAddr[i][cyc] = expRdAddr[i][cyc];
      clearFrom(i, cyc);
      freeAt[i] = cyc;
    end
    @(posedge clk);
    #1;
    resetn = 1'b0;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) applyStimulus(1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    cyc     = 0;
    resetn  = 1'b1;
    reqVld  = 1'b0;
    reqAddr = '0;
    flush   = 1'b0;
    memData[0] = '0;
    memData[1] = '0;
    for (int i = 0; i < 2; i++) begin
      clearFrom(i, 0);
      freeAt[i] = 0;
      for (int c = 0; c < NCYC; c++) begin
        histEn[i][c]   = 1'b0;
        histAddr[i][c] = '0;
      end
    end
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b0;
    $display("[TB] reset released");

    idle(2);
    // Critical-word-first line from the middle of the line.
    applyStimulus(1'b1, 32'h0000_1008, 1'b0);
    idle(12);
    // Back-to-back requests with the second one held valid.
    applyStimulus(1'b1, 32'h0000_2000, 1'b0);
    for (int j = 0; j < 12; j++) applyStimulus(1'b1, 32'h0000_3004, 1'b0);
    idle(14);
    // Flush during issue.
    applyStimulus(1'b1, 32'h0000_1008, 1'b0);
    idle(2);
    applyStimulus(1'b0, 32'h0, 1'b1);
    idle(12);
    // Flush while beats are streaming.
    applyStimulus(1'b1, 32'h0000_1008, 1'b0);
    idle(4);
    applyStimulus(1'b0, 32'h0, 1'b1);
    idle(12);
    // Flush together with a request in idle.
    applyStimulus(1'b1, 32'h0000_5000, 1'b1);
    idle(2);
    applyStimulus(1'b1, 32'h0000_4010, 1'b0);
    idle(12);
    // Asynchronous reset in the middle of a fill.
    applyStimulus(1'b1, 32'h0000_1008, 1'b0);
    idle(4);
    midReset();
    idle(12);

    $display("[TB] random phase");
    for (int n = 0; n < 300; n++)
      applyStimulus($urandom_range(0, 2) == 0, $urandom, $urandom_range(0, 15) == 0);
    idle(14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
